// File: rtl/chess_pkg.sv
// Shared chess definitions: square codes, color bit, start position and writer FSM states.
package chess_pkg;

  localparam logic [2:0] PIECE_EMPTY  = 3'd0;
  localparam logic [2:0] PIECE_PAWN   = 3'd1;
  localparam logic [2:0] PIECE_KNIGHT = 3'd2;
  localparam logic [2:0] PIECE_BISHOP = 3'd3;
  localparam logic [2:0] PIECE_ROOK   = 3'd4;
  localparam logic [2:0] PIECE_QUEEN  = 3'd5;
  localparam logic [2:0] PIECE_KING   = 3'd6;

  localparam int unsigned COLOR_BIT = 3;
  localparam logic COLOR_WHITE = 1'b0;
  localparam logic COLOR_BLACK = 1'b1;

  // Square n occupies bits [4n+3:4n]; rows listed top (row 7) to bottom (row 0).
  localparam logic [255:0] INIT_BOARD = {
    32'hCABEDBAC,
    32'h99999999,
    128'h0,
    32'h11111111,
    32'h42365324
  };

  typedef enum logic [1:0] {
    IDLE,
    SELECTED,
    COMMIT
  } state_t;

  function automatic logic is_own_piece(input logic [3:0] sq, input logic turn);
    return (sq[2:0] != PIECE_EMPTY) && (sq[COLOR_BIT] == turn);
  endfunction

endpackage

// File: rtl/chess_board_writer_btn_edge.sv
// 5-bit rising-edge detector; previous samples reset high so a held button needs a release first.
module btn_edge (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [4:0] btn,
  output logic [4:0] rise
);

  logic [4:0] prev;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) prev <= '1;
    else       prev <= btn;
  end

  assign rise = btn & ~prev;

endmodule

// File: rtl/chess_board_writer.sv
// Board state owner: cursor motion, selection and committed moves.
// Optional PAWN_PROMOTE_EN: pawns reaching the far rank become queens.
module chess_board_writer
  import chess_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET,
  input  logic         BTN_UP,
  input  logic         BTN_DOWN,
  input  logic         BTN_LEFT,
  input  logic         BTN_RIGHT,
  input  logic         BTN_SEL,
  output logic [255:0] BOARD,
  output logic [5:0]   CURSOR_ADDR,
  output logic [5:0]   SELECT_ADDR,
  output logic         SELECT_EN,
  output logic         TURN,
  output logic         MOVE_DONE
);

  logic [4:0] rise;
  logic [5:0] cursor_next;
  logic [5:0] dest;
  logic [3:0] cur_piece;
  logic [3:0] sel_piece;
  logic [3:0] moved_piece;
  logic       own_at_cursor;
  state_t     state;

  btn_edge u_btn_edge (
    .CLK  (CLK),
    .RESET(RESET),
    .btn  ({BTN_SEL, BTN_RIGHT, BTN_LEFT, BTN_DOWN, BTN_UP}),
    .rise (rise)
  );

  always_comb begin
    cursor_next = CURSOR_ADDR;
    if (rise[0]) begin
      if (CURSOR_ADDR[5:3] != 3'd7) cursor_next = {CURSOR_ADDR[5:3] + 3'd1, CURSOR_ADDR[2:0]};
    end else if (rise[1]) begin
      if (CURSOR_ADDR[5:3] != 3'd0) cursor_next = {CURSOR_ADDR[5:3] - 3'd1, CURSOR_ADDR[2:0]};
    end else if (rise[2]) begin
      if (CURSOR_ADDR[2:0] != 3'd0) cursor_next = {CURSOR_ADDR[5:3], CURSOR_ADDR[2:0] - 3'd1};
    end else if (rise[3]) begin
      if (CURSOR_ADDR[2:0] != 3'd7) cursor_next = {CURSOR_ADDR[5:3], CURSOR_ADDR[2:0] + 3'd1};
    end
  end

  always_comb begin
    cur_piece     = BOARD[{CURSOR_ADDR, 2'b00} +: 4];
    sel_piece     = BOARD[{SELECT_ADDR, 2'b00} +: 4];
    own_at_cursor = is_own_piece(cur_piece, TURN);
    moved_piece   = sel_piece;
`ifdef PAWN_PROMOTE_EN
    if (sel_piece[2:0] == PIECE_PAWN &&
        ((sel_piece[COLOR_BIT] == COLOR_WHITE && dest[5:3] == 3'd7) ||
         (sel_piece[COLOR_BIT] == COLOR_BLACK && dest[5:3] == 3'd0)))
      moved_piece = {sel_piece[COLOR_BIT], PIECE_QUEEN};
`endif
  end

  // SEL always evaluates the pre-move cursor; the cursor still moves that same cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      BOARD       <= INIT_BOARD;
      CURSOR_ADDR <= '0;
      SELECT_ADDR <= '0;
      SELECT_EN   <= 1'b0;
      TURN        <= COLOR_WHITE;
      MOVE_DONE   <= 1'b0;
      dest        <= '0;
      state       <= IDLE;
    end else begin
      MOVE_DONE <= 1'b0;
      case (state)
        IDLE: begin
          CURSOR_ADDR <= cursor_next;
          if (rise[4] && own_at_cursor) begin
            SELECT_ADDR <= CURSOR_ADDR;
            SELECT_EN   <= 1'b1;
            state       <= SELECTED;
          end
        end
        SELECTED: begin
          CURSOR_ADDR <= cursor_next;
          if (rise[4]) begin
            if (CURSOR_ADDR == SELECT_ADDR) begin
              SELECT_EN <= 1'b0;
              state     <= IDLE;
            end else if (own_at_cursor) begin
              SELECT_ADDR <= CURSOR_ADDR;
            end else begin
              dest  <= CURSOR_ADDR;
              state <= COMMIT;
            end
          end
        end
        COMMIT: begin
          BOARD[{dest, 2'b00} +: 4]        <= moved_piece;
          BOARD[{SELECT_ADDR, 2'b00} +: 4] <= '0;
          SELECT_EN <= 1'b0;
          TURN      <= ~TURN;
          MOVE_DONE <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/chess_board_writer.md
# chess_board_writer

Owns the authoritative 64-square board state and the cursor/selection registers consumed by the VGA display block. Converts synchronized player buttons into cursor motion, piece selection and committed moves, and drives BOARD, CURSOR_ADDR, SELECT_ADDR and SELECT_EN. Move legality is limited to turn/color ownership; full chess rules live in a later block.

## Interface
- No parameters; geometry is fixed at 8x8 with 4-bit squares.
- CLK  input  1  system clock, all logic on rising edge
- RESET  input  1  reset, asynchronous, active-high
- BTN_UP / BTN_DOWN / BTN_LEFT / BTN_RIGHT  input  1 each  synchronized, debounced levels
- BTN_SEL  input  1  synchronized, debounced select level
- BOARD  output  256  square n at BOARD[4n+3:4n]
- CURSOR_ADDR  output  6  cursor square, {row[2:0], col[2:0]}
- SELECT_ADDR  output  6  selected square; valid only when SELECT_EN=1
- SELECT_EN  output  1  a piece is currently selected
- TURN  output  1  side to move: 0 white, 1 black
- MOVE_DONE  output  1  one-cycle pulse on each committed move

## Operation
- Square code: bit3 = color (0 white, 1 black); bits[2:0] = 0 empty, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king; 7 reserved, never written.
- Row 0 is the white back rank; up = row+1, right = col+1.
- Reset values: BOARD = standard start position (row0 4,2,3,5,6,3,2,4 white; row1 white pawns; row6 black pawns, code 4'h9; row7 black back rank; rows 2-5 zero); CURSOR_ADDR = 6'd0; SELECT_ADDR = 6'd0; SELECT_EN = 0; TURN = 0; MOVE_DONE = 0; FSM = IDLE.
- Button events are rising edges: level=1 with the previous sample 0. Previous-sample registers reset to 1, so a button held through reset release produces no event until released and pressed again.
- Cursor: at most one move per cycle, priority UP > DOWN > LEFT > RIGHT. Saturates at board edges with no wrap: UP at row 7 is a no-op.
- FSM states:
  - IDLE: SEL on a square holding a TURN-color piece -> SELECTED, with SELECT_ADDR = cursor and SELECT_EN = 1. SEL on any other square is ignored.
  - SELECTED, SEL on SELECT_ADDR: deselect -> IDLE, SELECT_EN = 0.
  - SELECTED, SEL on another own-color piece: reselect; SELECT_ADDR = cursor; stay in SELECTED.
  - SELECTED, SEL on an empty or opponent square: latch that square as the destination -> COMMIT.
  - COMMIT (exactly one cycle): board[dest] = board[SELECT_ADDR]; board[SELECT_ADDR] = 0; SELECT_EN = 0; TURN toggles; MOVE_DONE = 1 -> IDLE. Button events in the COMMIT cycle are dropped, cursor moves included.
- Simultaneous direction and SEL events: SEL evaluates the pre-move CURSOR_ADDR, and the cursor moves in the same cycle.
- RESET mid-COMMIT: the board returns to the start position and no MOVE_DONE pulse is issued.

## Timing
- Cursor and selection latency: outputs update on the same rising edge that samples the button's 0->1 transition.
- Move latency: the SEL edge at cycle n enters COMMIT. BOARD, TURN and MOVE_DONE update at edge n+1. MOVE_DONE deasserts at edge n+2.
- All outputs are registered, with no combinational path from inputs to outputs.
- BOARD changes only in COMMIT or on reset. The display may sample it on any cycle.

## Configuration
- PAWN_PROMOTE_EN defined: in COMMIT, a pawn landing on the far rank (white on row 7, black on row 0) is written as a queen of the same color (4'h5 / 4'hD).
- PAWN_PROMOTE_EN undefined: the piece is copied unchanged.

## Structure
- Shared package chess_pkg holds: piece-type constants, color bit index, COLOR_WHITE/COLOR_BLACK, INIT_BOARD 256-bit constant, and FSM state encoding (IDLE, SELECTED, COMMIT). The display block uses the same package.
- One sub-module, btn_edge: a 5-bit rising-edge detector with previous-sample registers reset to 1. Instantiated once.

## Test plan
- Reset, then idle 10 cycles -> BOARD == INIT_BOARD, CURSOR_ADDR = 0, SELECT_EN = 0, TURN = 0, MOVE_DONE never high.
- LEFT at cursor 0; then 8 UP pulses -> cursor stays 0; then ends at 6'd56 (saturated at row 7).
- Cursor 12, SEL, UP, UP, SEL (e2-e4) -> SELECT_ADDR = 12; then square 28 = 4'h1, square 12 = 0, TURN = 1; MOVE_DONE high exactly one cycle.
- With TURN = 0: SEL on square 52 (black pawn) -> ignored. SEL on 12 twice -> select, then deselect (SELECT_EN 1 then 0), BOARD unchanged.
- UP and SEL in the same cycle at cursor 8 -> SELECT_ADDR = 8, CURSOR_ADDR = 16. Assert RESET during COMMIT -> INIT_BOARD, no MOVE_DONE.
- With PAWN_PROMOTE_EN: white pawn preloaded via move sequence onto row 6, moved to empty row 7 -> destination = 4'h5. Without the macro -> 4'h1.
